ldst_bus_unit: RTL and testbench

Parametrised load/store unit between the CPU execute stage and the Avalon-style data port (o_ldst_* / i_ldst_*). It accepts one memory request at a time, generates the aligned bus address, byte enables and lane-shifted write data, and holds the command stable while i_ldst_waitrequest is high. It returns sign- or zero-extended load data, or flags misaligned and illegal accesses without touching the bus. It generalises the fixed 32-bit, zero-latency data port to configurable data width and read latency.

---
 rtl/ldst_bus_unit.sv | 95 +++++++++
 tb/tb_ldst_bus_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_bus_unit.sv
// ldst_bus_unit: single-outstanding load/store unit driving an Avalon-style data port
module ldst_bus_unit #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_wr,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsigned,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wrdata,
  output logic                o_resp_valid,
  output logic [DATA_W-1:0]   o_resp_rddata,
  output logic                o_resp_err,
  output logic                o_busy,
  output logic [ADDR_W-1:0]   o_ldst_addr,
  output logic                o_ldst_rd,
  output logic                o_ldst_wr,
  output logic [DATA_W-1:0]   o_ldst_wrdata,
  output logic [DATA_W/8-1:0] o_ldst_byte_en,
  input  logic [DATA_W-1:0]   i_ldst_rddata,
  input  logic                i_ldst_waitrequest
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, BUS, RDWAIT, ERR} state_t;
  state_t state, state_nx;
  logic [OW-1:0] off, off_q;
  logic [1:0] size_q;
  logic uns_q, bad, accept, bus_done, resp_fire, sext;
  logic [7:0] top;
  logic [DATA_W-1:0] shifted, mask, loaded;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    off       = i_req_addr[OW-1:0];
    bad       = ((DATA_W == 32) && i_req_size == 2'd3) ||
                ((i_req_addr[2:0] & ((3'd1 << i_req_size) - 3'd1)) != 3'd0);
    accept    = i_req_valid && state == IDLE;
    bus_done  = state == BUS && !i_ldst_waitrequest;
    resp_fire = (bus_done && (o_ldst_wr || READ_LATENCY == 0)) || state == RDWAIT || state == ERR;
    state_nx  = state == IDLE ? (accept ? (bad ? ERR : BUS) : IDLE) :
                state == BUS  ? (i_ldst_waitrequest ? BUS :
                                 (!o_ldst_wr && READ_LATENCY != 0) ? RDWAIT : IDLE) :
                IDLE;
  end
  always_comb begin
    o_req_ready = state == IDLE;
    o_busy      = state != IDLE;
  end
  always_comb begin
    shifted = i_ldst_rddata >> {off_q, 3'b000};
    mask    = ~({DATA_W{1'b1}} << (7'd8 << size_q));
    top     = (8'd8 << size_q) - 8'd1;
    sext    = !uns_q && size_q != 2'(OW) && shifted[top[IW-1:0]];
    loaded  = sext ? (shifted | ~mask) : (shifted & mask);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      o_ldst_addr    <= '0;
      o_ldst_rd      <= 1'b0;
      o_ldst_wr      <= 1'b0;
      o_ldst_wrdata  <= '0;
      o_ldst_byte_en <= '0;
      o_resp_valid   <= 1'b0;
      o_resp_err     <= 1'b0;
      o_resp_rddata  <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      off_q          <= '0;
    end else begin
      o_resp_valid  <= resp_fire;
      o_resp_err    <= state == ERR;
      o_resp_rddata <= (resp_fire && state != ERR && !o_ldst_wr) ? loaded : '0;
      if (accept && !bad) begin
        o_ldst_addr    <= {i_req_addr[ADDR_W-1:OW], {OW{1'b0}}};
        o_ldst_rd      <= !i_req_wr;
        o_ldst_wr      <= i_req_wr;
        o_ldst_wrdata  <= i_req_wrdata << {off, 3'b000};
        o_ldst_byte_en <= NB'((16'd1 << (5'd1 << i_req_size)) - 16'd1) << off;
        size_q         <= i_req_size;
        uns_q          <= i_req_unsigned;
        off_q          <= off;
      end else if (bus_done) begin
        o_ldst_rd <= 1'b0;
        o_ldst_wr <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ldst_bus_unit.sv
// tb_ldst_bus_unit: directed checks of ldst_bus_unit at 32-bit/latency-0 and 64-bit/latency-1
module tb_ldst_bus_unit;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic a_valid, a_ready, a_wr, a_uns, a_rvalid, a_err, a_busy, a_rd, a_lwr, a_wait;
  logic [1:0] a_size;
  logic [31:0] a_addr, a_wrdata, a_rdata, a_laddr, a_lwdata, a_rddata;
  logic [3:0] a_be;
  logic b_valid, b_ready, b_wr, b_uns, b_rvalid, b_err, b_busy, b_rd, b_lwr, b_wait;
  logic [1:0] b_size;
  logic [31:0] b_addr, b_laddr;
  logic [63:0] b_wrdata, b_rdata, b_lwdata, b_rddata;
  logic [7:0] b_be;
  ldst_bus_unit #(.DATA_W(32), .ADDR_W(32), .READ_LATENCY(0)) dut_a (
    .clk(clk), .reset(reset), .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_wr(a_wr),
    .i_req_size(a_size), .i_req_unsigned(a_uns), .i_req_addr(a_addr), .i_req_wrdata(a_wrdata),
    .o_resp_valid(a_rvalid), .o_resp_rddata(a_rdata), .o_resp_err(a_err), .o_busy(a_busy),
    .o_ldst_addr(a_laddr), .o_ldst_rd(a_rd), .o_ldst_wr(a_lwr), .o_ldst_wrdata(a_lwdata),
    .o_ldst_byte_en(a_be), .i_ldst_rddata(a_rddata), .i_ldst_waitrequest(a_wait));
  ldst_bus_unit #(.DATA_W(64), .ADDR_W(32), .READ_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_wr(b_wr),
    .i_req_size(b_size), .i_req_unsigned(b_uns), .i_req_addr(b_addr), .i_req_wrdata(b_wrdata),
    .o_resp_valid(b_rvalid), .o_resp_rddata(b_rdata), .o_resp_err(b_err), .o_busy(b_busy),
    .o_ldst_addr(b_laddr), .o_ldst_rd(b_rd), .o_ldst_wr(b_lwr), .o_ldst_wrdata(b_lwdata),
    .o_ldst_byte_en(b_be), .i_ldst_rddata(b_rddata), .i_ldst_waitrequest(b_wait));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue_a(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    a_valid = 1; a_wr = wr; a_size = size; a_uns = uns; a_addr = addr; a_wrdata = wd;
    step;
    a_valid = 0;
  endtask
  task automatic issue_b(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wd);
    b_valid = 1; b_wr = wr; b_size = size; b_uns = uns; b_addr = addr; b_wrdata = wd;
    step;
    b_valid = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    step;
    step;
    checks++;
    if ({a_rd, a_lwr, a_rvalid, a_err, a_busy, a_ready} !== 6'b000001) begin
      errors++; $display("FAIL reset_ctrl_a: got %b expected 000001", {a_rd, a_lwr, a_rvalid, a_err, a_busy, a_ready});
    end
    checks++;
    if ({a_laddr, a_lwdata, a_be, a_rdata} !== 100'd0) begin
      errors++; $display("FAIL reset_data_a: got %h expected 0", {a_laddr, a_lwdata, a_be, a_rdata});
    end
    checks++;
    if ({b_rd, b_lwr, b_rvalid, b_err, b_busy, b_ready, b_be} !== 14'b000001_00000000) begin
      errors++; $display("FAIL reset_b: got %b expected 00000100000000", {b_rd, b_lwr, b_rvalid, b_err, b_busy, b_ready, b_be});
    end
    reset = 0;
  endtask
  task automatic test_lw_wait;
    a_wait = 1; a_rddata = 0;
    issue_a(0, 2'd2, 0, 32'h4, 0);
    for (int i = 0; i < 21; i++) begin
      if (i == 20) begin a_wait = 0; a_rddata = 32'h12345678; end
      checks++;
      if ({a_laddr, a_rd, a_lwr, a_be, a_busy, a_rvalid} !== {32'h4, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0}) begin
        errors++; $display("FAIL lw_hold cyc%0d: got addr=%h rd=%b wr=%b be=%h busy=%b rv=%b expected addr=4 rd=1 wr=0 be=f busy=1 rv=0",
                            i, a_laddr, a_rd, a_lwr, a_be, a_busy, a_rvalid);
      end
      step;
    end
    checks++;
    if ({a_rvalid, a_err, a_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      errors++; $display("FAIL lw_resp: got v=%b e=%b d=%h expected v=1 e=0 d=12345678", a_rvalid, a_err, a_rdata);
    end
    checks++;
    if ({a_rd, a_ready, a_busy} !== 3'b010) begin
      errors++; $display("FAIL lw_idle: got rd/ready/busy=%b expected 010", {a_rd, a_ready, a_busy});
    end
    step;
    checks++;
    if (a_rvalid !== 1'b0) begin
      errors++; $display("FAIL lw_pulse: got rv=%b expected 0", a_rvalid);
    end
  endtask
  task automatic test_lb_lbu;
    a_wait = 0; a_rddata = 32'h80FF1234;
    issue_a(0, 2'd0, 0, 32'h7, 0);
    checks++;
    if ({a_laddr, a_be, a_rd} !== {32'h4, 4'b1000, 1'b1}) begin
      errors++; $display("FAIL lb_cmd: got addr=%h be=%b rd=%b expected addr=4 be=1000 rd=1", a_laddr, a_be, a_rd);
    end
    step;
    checks++;
    if ({a_rvalid, a_rdata, a_ready} !== {1'b1, 32'hFFFFFF80, 1'b1}) begin
      errors++; $display("FAIL lb_resp: got v=%b d=%h ready=%b expected v=1 d=ffffff80 ready=1", a_rvalid, a_rdata, a_ready);
    end
    issue_a(0, 2'd0, 1, 32'h7, 0);
    step;
    checks++;
    if ({a_rvalid, a_rdata} !== {1'b1, 32'h00000080}) begin
      errors++; $display("FAIL lbu_resp: got v=%b d=%h expected v=1 d=00000080", a_rvalid, a_rdata);
    end
  endtask
  task automatic test_sh;
    a_wait = 1;
    issue_a(1, 2'd1, 0, 32'h6, 32'h0000ABCD);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) a_wait = 0;
      checks++;
      if ({a_laddr, a_be, a_lwdata, a_lwr, a_rd} !== {32'h4, 4'b1100, 32'hABCD0000, 1'b1, 1'b0}) begin
        errors++; $display("FAIL sh_hold cyc%0d: got addr=%h be=%b wd=%h wr=%b rd=%b expected addr=4 be=1100 wd=abcd0000 wr=1 rd=0",
                            i, a_laddr, a_be, a_lwdata, a_lwr, a_rd);
      end
      step;
    end
    checks++;
    if ({a_rvalid, a_err, a_rdata, a_lwr} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL sh_resp: got v=%b e=%b d=%h wr=%b expected v=1 e=0 d=0 wr=0", a_rvalid, a_err, a_rdata, a_lwr);
    end
  endtask
  task automatic test_errors;
    logic [1:0] sz [2];
    logic [31:0] ad [2];
    sz[0] = 2'd1; ad[0] = 32'h5;
    sz[1] = 2'd3; ad[1] = 32'h8;
    a_wait = 0;
    for (int k = 0; k < 2; k++) begin
      issue_a(0, sz[k], 0, ad[k], 0);
      checks++;
      if ({a_rd, a_lwr, a_rvalid, a_busy} !== 4'b0001) begin
        errors++; $display("FAIL err%0d_cyc1: got rd/wr/rv/busy=%b expected 0001", k, {a_rd, a_lwr, a_rvalid, a_busy});
      end
      step;
      checks++;
      if ({a_rvalid, a_err, a_rd, a_lwr, a_rdata} !== {4'b1100, 32'h0}) begin
        errors++; $display("FAIL err%0d_resp: got v=%b e=%b rd=%b wr=%b d=%h expected v=1 e=1 rd=0 wr=0 d=0",
                            k, a_rvalid, a_err, a_rd, a_lwr, a_rdata);
      end
      step;
      checks++;
      if ({a_rvalid, a_err} !== 2'b00) begin
        errors++; $display("FAIL err%0d_pulse: got v/e=%b expected 00", k, {a_rvalid, a_err});
      end
    end
  endtask
  task automatic test_reset_abort;
    int seen;
    a_wait = 1;
    issue_a(0, 2'd2, 0, 32'h8, 0);
    step;
    checks++;
    if ({a_rd, a_laddr} !== {1'b1, 32'h8}) begin
      errors++; $display("FAIL abort_pre: got rd=%b addr=%h expected rd=1 addr=8", a_rd, a_laddr);
    end
    reset = 1;
    step;
    reset = 0;
    checks++;
    if ({a_rd, a_busy, a_rvalid, a_ready} !== 4'b0001) begin
      errors++; $display("FAIL abort_post: got rd/busy/rv/ready=%b expected 0001", {a_rd, a_busy, a_rvalid, a_ready});
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (a_rvalid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_noresp: got %0d pulses expected 0", seen);
    end
    a_wait = 0; a_rddata = 32'hCAFEF00D;
    issue_a(0, 2'd2, 0, 32'hC, 0);
    checks++;
    if ({a_laddr, a_rd} !== {32'hC, 1'b1}) begin
      errors++; $display("FAIL after_abort_cmd: got addr=%h rd=%b expected addr=c rd=1", a_laddr, a_rd);
    end
    step;
    checks++;
    if ({a_rvalid, a_err, a_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++; $display("FAIL after_abort_resp: got v=%b e=%b d=%h expected v=1 e=0 d=cafef00d", a_rvalid, a_err, a_rdata);
    end
  endtask
  task automatic test_wide_rl1;
    logic [63:0] exp [2];
    exp[0] = 64'hFFFFFFFF_DEADBEEF;
    exp[1] = 64'h00000000_DEADBEEF;
    b_wait = 0;
    for (int k = 0; k < 2; k++) begin
      b_rddata = 0;
      issue_b(0, 2'd2, k[0], 32'h14, 0);
      checks++;
      if ({b_laddr, b_be, b_rd} !== {32'h10, 8'hF0, 1'b1}) begin
        errors++; $display("FAIL wide%0d_cmd: got addr=%h be=%h rd=%b expected addr=10 be=f0 rd=1", k, b_laddr, b_be, b_rd);
      end
      step;
      checks++;
      if ({b_rd, b_rvalid, b_busy} !== 3'b001) begin
        errors++; $display("FAIL wide%0d_rdwait: got rd/rv/busy=%b expected 001", k, {b_rd, b_rvalid, b_busy});
      end
      b_rddata = 64'hDEADBEEF_00000000;
      step;
      checks++;
      if ({b_rvalid, b_err, b_rdata} !== {1'b1, 1'b0, exp[k]}) begin
        errors++; $display("FAIL wide%0d_resp: got v=%b e=%b d=%h expected v=1 e=0 d=%h", k, b_rvalid, b_err, b_rdata, exp[k]);
      end
    end
    issue_b(1, 2'd3, 0, 32'h8, 64'h11223344_55667788);
    checks++;
    if ({b_laddr, b_be, b_lwdata, b_lwr} !== {32'h8, 8'hFF, 64'h11223344_55667788, 1'b1}) begin
      errors++; $display("FAIL sd_cmd: got addr=%h be=%h wd=%h wr=%b expected addr=8 be=ff wd=1122334455667788 wr=1",
                          b_laddr, b_be, b_lwdata, b_lwr);
    end
    step;
    checks++;
    if ({b_rvalid, b_err, b_lwr} !== 3'b100) begin
      errors++; $display("FAIL sd_resp: got v/e/wr=%b expected 100", {b_rvalid, b_err, b_lwr});
    end
  endtask
  initial begin
    a_valid = 0; a_wr = 0; a_size = 0; a_uns = 0; a_addr = 0; a_wrdata = 0; a_rddata = 0; a_wait = 0;
    b_valid = 0; b_wr = 0; b_size = 0; b_uns = 0; b_addr = 0; b_wrdata = 0; b_rddata = 0; b_wait = 0;
    test_reset;
    test_lw_wait;
    test_lb_lbu;
    test_sh;
    test_errors;
    test_reset_abort;
    test_wide_rl1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
